bps_mc_bridge: RTL and testbench

Request/response buffer between the `bps` message-passing engine and the memory-controller port. Queues `bps` load/store requests and issues them to the memory controller while honouring `mc_req_stall`. Caps in-flight loads with a credit counter and buffers load responses, so `bps` can assert its own response back-pressure without losing data. Placed directly on the `mc_*` side of `bps`: `bps` drives the `up_*` request ports, and the controller sees the `mc_*` ports.

---
 rtl/bps_mc_bridge.sv | 166 ++++++++++++++++
 tb/tb_bps_mc_bridge.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bps_mc_bridge.sv
// Request/response buffer between the bps engine and a memory-controller port.
// Define BPS_MC_BRIDGE_STATS_EN to add the stat_ld/stat_st/stat_stall counters.

module bps_mc_bridge #(
    parameter int unsigned REQ_DEPTH = 8,
    parameter int unsigned REQ_SLACK = 2,
    parameter int unsigned MAX_OUT   = 8,
    parameter int unsigned RSP_SLACK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req_ld,
    input  logic        up_req_st,
    input  logic [47:0] up_req_vadr,
    input  logic [63:0] up_req_wrd_rdctl,
    output logic        up_req_stall,
    output logic        mc_req_ld,
    output logic        mc_req_st,
    output logic [47:0] mc_req_vadr,
    output logic [63:0] mc_req_wrd_rdctl,
    input  logic        mc_req_stall,
    input  logic        mc_rsp_push,
    input  logic [31:0] mc_rsp_rdctl,
    input  logic [63:0] mc_rsp_data,
    output logic        mc_rsp_stall,
    output logic        up_rsp_push,
    output logic [31:0] up_rsp_rdctl,
    output logic [63:0] up_rsp_data,
    input  logic        up_rsp_stall,
    output logic        err
`ifdef BPS_MC_BRIDGE_STATS_EN
    ,
    output logic [31:0] stat_ld,
    output logic [31:0] stat_st,
    output logic [31:0] stat_stall
`endif
);

    localparam int unsigned QA = $clog2(REQ_DEPTH);
    localparam int unsigned QW = QA + 1;
    localparam int unsigned RA = $clog2(MAX_OUT);
    localparam int unsigned RW = RA + 1;
    localparam logic [QW-1:0] REQ_FULL = QW'(REQ_DEPTH);
    localparam logic [QW-1:0] REQ_HI   = QW'(REQ_DEPTH - REQ_SLACK);
    localparam logic [RW-1:0] RSP_FULL = RW'(MAX_OUT);
    localparam logic [RW-1:0] RSP_HI   = RW'(MAX_OUT - RSP_SLACK);

    typedef struct packed {
        logic        st;
        logic        ld;
        logic [47:0] vadr;
        logic [63:0] wrd;
    } req_t;

    typedef struct packed {
        logic [31:0] rdctl;
        logic [63:0] data;
    } rsp_t;

    req_t          req_mem [REQ_DEPTH];
    rsp_t          rsp_mem [MAX_OUT];
    logic [QA-1:0] req_wp, req_rp;
    logic [RA-1:0] rsp_wp, rsp_rp;
    logic [QW-1:0] req_cnt, req_cnt_nxt;
    logic [RW-1:0] rsp_cnt, rsp_cnt_nxt;
    logic [RW-1:0] outstanding, out_nxt;

    req_t req_in, req_head;
    rsp_t rsp_in, rsp_head;
    logic req_valid, req_empty, req_full, req_pop, req_byp, req_wr, req_rd, req_err, ld_iss;
    logic rsp_in_ok, rsp_empty, rsp_full, rsp_pop, rsp_byp, rsp_wr, rsp_rd, rsp_err;

    // An empty FIFO forwards the incoming entry directly, giving one-cycle latency.
    always_comb begin
        req_in      = '{st: up_req_st, ld: up_req_ld, vadr: up_req_vadr, wrd: up_req_wrd_rdctl};
        req_valid   = up_req_ld ^ up_req_st;
        req_empty   = (req_cnt == '0);
        req_full    = (req_cnt == REQ_FULL);
        req_head    = req_empty ? req_in : req_mem[req_rp];
        req_pop     = (!req_empty || req_valid) && !mc_req_stall
                      && (req_head.st || (outstanding < RSP_FULL));
        req_byp     = req_empty && req_pop;
        req_wr      = req_valid && !req_byp && (!req_full || req_pop);
        req_rd      = req_pop && !req_empty;
        req_err     = (up_req_ld && up_req_st) || (req_valid && !req_wr && !req_byp);
        req_cnt_nxt = req_cnt + QW'(req_wr) - QW'(req_rd);
        ld_iss      = req_pop && req_head.ld;

        rsp_in      = '{rdctl: mc_rsp_rdctl, data: mc_rsp_data};
        rsp_in_ok   = mc_rsp_push && (outstanding != '0);
        rsp_empty   = (rsp_cnt == '0);
        rsp_full    = (rsp_cnt == RSP_FULL);
        rsp_head    = rsp_empty ? rsp_in : rsp_mem[rsp_rp];
        rsp_pop     = (!rsp_empty || rsp_in_ok) && !up_rsp_stall;
        rsp_byp     = rsp_empty && rsp_pop;
        rsp_wr      = rsp_in_ok && !rsp_byp && (!rsp_full || rsp_pop);
        rsp_rd      = rsp_pop && !rsp_empty;
        rsp_err     = mc_rsp_push && !rsp_wr && !rsp_byp;
        rsp_cnt_nxt = rsp_cnt + RW'(rsp_wr) - RW'(rsp_rd);
        out_nxt     = outstanding + RW'(ld_iss) - RW'(rsp_pop && (outstanding != '0));
    end

    always_ff @(posedge clk) begin
        if (req_wr) req_mem[req_wp] <= req_in;
        if (rsp_wr) rsp_mem[rsp_wp] <= rsp_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_wp           <= '0;
            req_rp           <= '0;
            req_cnt          <= '0;
            rsp_wp           <= '0;
            rsp_rp           <= '0;
            rsp_cnt          <= '0;
            outstanding      <= '0;
            mc_req_ld        <= 1'b0;
            mc_req_st        <= 1'b0;
            mc_req_vadr      <= '0;
            mc_req_wrd_rdctl <= '0;
            up_req_stall     <= 1'b0;
            up_rsp_push      <= 1'b0;
            up_rsp_rdctl     <= '0;
            up_rsp_data      <= '0;
            mc_rsp_stall     <= 1'b0;
            err              <= 1'b0;
        end else begin
            req_wp       <= req_wp + QA'(req_wr);
            req_rp       <= req_rp + QA'(req_rd);
            req_cnt      <= req_cnt_nxt;
            rsp_wp       <= rsp_wp + RA'(rsp_wr);
            rsp_rp       <= rsp_rp + RA'(rsp_rd);
            rsp_cnt      <= rsp_cnt_nxt;
            outstanding  <= out_nxt;
            mc_req_ld    <= ld_iss;
            mc_req_st    <= req_pop && req_head.st;
            if (req_pop) begin
                mc_req_vadr      <= req_head.vadr;
                mc_req_wrd_rdctl <= req_head.wrd;
            end
            up_req_stall <= (req_cnt_nxt >= REQ_HI);
            up_rsp_push  <= rsp_pop;
            if (rsp_pop) begin
                up_rsp_rdctl <= rsp_head.rdctl;
                up_rsp_data  <= rsp_head.data;
            end
            mc_rsp_stall <= (rsp_cnt_nxt >= RSP_HI);
            err          <= err || req_err || rsp_err;
        end
    end

`ifdef BPS_MC_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ld    <= '0;
            stat_st    <= '0;
            stat_stall <= '0;
        end else begin
            stat_ld    <= stat_ld + 32'(ld_iss);
            stat_st    <= stat_st + 32'(req_pop && req_head.st);
            stat_stall <= stat_stall + 32'(!req_empty && mc_req_stall);
        end
    end
`endif

endmodule

// File: tb/tb_bps_mc_bridge.sv
// Self-checking bench for bps_mc_bridge: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_bps_mc_bridge;

    localparam int REQ_DEPTH = 8;
    localparam int REQ_SLACK = 2;
    localparam int MAX_OUT   = 8;
    localparam int RSP_SLACK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_req_ld = 1'b0;
    logic        up_req_st = 1'b0;
    logic [47:0] up_req_vadr = '0;
    logic [63:0] up_req_wrd_rdctl = '0;
    logic        up_req_stall;
    logic        mc_req_ld;
    logic        mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic        mc_req_stall = 1'b0;
    logic        mc_rsp_push = 1'b0;
    logic [31:0] mc_rsp_rdctl = '0;
    logic [63:0] mc_rsp_data = '0;
    logic        mc_rsp_stall;
    logic        up_rsp_push;
    logic [31:0] up_rsp_rdctl;
    logic [63:0] up_rsp_data;
    logic        up_rsp_stall = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    bps_mc_bridge #(
        .REQ_DEPTH(REQ_DEPTH),
        .REQ_SLACK(REQ_SLACK),
        .MAX_OUT  (MAX_OUT),
        .RSP_SLACK(RSP_SLACK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .up_req_ld       (up_req_ld),
        .up_req_st       (up_req_st),
        .up_req_vadr     (up_req_vadr),
        .up_req_wrd_rdctl(up_req_wrd_rdctl),
        .up_req_stall    (up_req_stall),
        .mc_req_ld       (mc_req_ld),
        .mc_req_st       (mc_req_st),
        .mc_req_vadr     (mc_req_vadr),
        .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
        .mc_req_stall    (mc_req_stall),
        .mc_rsp_push     (mc_rsp_push),
        .mc_rsp_rdctl    (mc_rsp_rdctl),
        .mc_rsp_data     (mc_rsp_data),
        .mc_rsp_stall    (mc_rsp_stall),
        .up_rsp_push     (up_rsp_push),
        .up_rsp_rdctl    (up_rsp_rdctl),
        .up_rsp_data     (up_rsp_data),
        .up_rsp_stall    (up_rsp_stall),
        .err             (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queues + credit count) ----------------
    typedef struct {
        bit          ld;
        bit          st;
        logic [47:0] vadr;
        logic [63:0] wrd;
    } mreq_t;

    mreq_t       mq_req[$];
    logic [95:0] mq_rsp[$];
    int          m_out = 0;
    bit          m_err = 0;
    bit          e_ld, e_st, e_push, e_req_stall, e_rsp_stall;
    logic [47:0] e_vadr;
    logic [63:0] e_wrd;
    logic [31:0] e_rdctl;
    logic [63:0] e_data;

    task automatic model_step();
        mreq_t       h, inc;
        bit          have, used;
        bit          rsp_ok;
        logic [95:0] rh;
        int          old_out;
        if (rst) begin
            mq_req.delete();
            mq_rsp.delete();
            m_out = 0; m_err = 0;
            e_ld = 0; e_st = 0; e_push = 0; e_req_stall = 0; e_rsp_stall = 0;
            return;
        end
        old_out  = m_out;
        inc.ld   = up_req_ld;
        inc.st   = up_req_st;
        inc.vadr = up_req_vadr;
        inc.wrd  = up_req_wrd_rdctl;
        have = 0; used = 0;
        if (mq_req.size() > 0) begin
            h = mq_req[0]; have = 1;
        end else if (up_req_ld != up_req_st) begin
            h = inc; have = 1;
        end
        e_ld = 0; e_st = 0;
        if (have && !mc_req_stall && (h.st || old_out < MAX_OUT)) begin
            if (mq_req.size() > 0) void'(mq_req.pop_front());
            else used = 1;
            e_ld = h.ld; e_st = h.st; e_vadr = h.vadr; e_wrd = h.wrd;
        end
        if (up_req_ld && up_req_st) m_err = 1;
        else if ((up_req_ld || up_req_st) && !used) begin
            if (mq_req.size() < REQ_DEPTH) mq_req.push_back(inc);
            else m_err = 1;
        end

        rsp_ok = mc_rsp_push && (old_out > 0);
        if (mc_rsp_push && !rsp_ok) m_err = 1;
        e_push = 0; used = 0;
        if (!up_rsp_stall) begin
            if (mq_rsp.size() > 0) begin
                rh = mq_rsp.pop_front(); e_push = 1;
            end else if (rsp_ok) begin
                rh = {mc_rsp_rdctl, mc_rsp_data}; e_push = 1; used = 1;
            end
            if (e_push) begin
                e_rdctl = rh[95:64]; e_data = rh[63:0];
            end
        end
        if (rsp_ok && !used) begin
            if (mq_rsp.size() < MAX_OUT) mq_rsp.push_back({mc_rsp_rdctl, mc_rsp_data});
            else m_err = 1;
        end
        m_out = old_out + (e_ld ? 1 : 0) - ((e_push && old_out > 0) ? 1 : 0);
        e_req_stall = (mq_req.size() >= REQ_DEPTH - REQ_SLACK);
        e_rsp_stall = (mq_rsp.size() >= MAX_OUT - RSP_SLACK);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("mc_req_ld", mc_req_ld, e_ld);
        chk("mc_req_st", mc_req_st, e_st);
        if (e_ld || e_st) begin
            chk("mc_req_vadr", mc_req_vadr, e_vadr);
            chk("mc_req_wrd_rdctl", mc_req_wrd_rdctl, e_wrd);
        end
        chk("up_rsp_push", up_rsp_push, e_push);
        if (e_push) begin
            chk("up_rsp_rdctl", up_rsp_rdctl, e_rdctl);
            chk("up_rsp_data", up_rsp_data, e_data);
        end
        chk("up_req_stall", up_req_stall, e_req_stall);
        chk("mc_rsp_stall", mc_rsp_stall, e_rsp_stall);
        chk("err", err, m_err);
    end

    // ---------------- controller stub ----------------
    typedef struct {
        logic [31:0] rdctl;
        logic [63:0] data;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    ctl_dmin = 0, ctl_dmax = 0;
    bit    spur_req = 0;

    always @(negedge clk) begin : ctl
        pend_t p;
        cyc++;
        if (mc_req_ld === 1'b1) begin
            p.rdctl = mc_req_wrd_rdctl[31:0];
            p.data  = {$urandom(), $urandom()};
            p.due   = cyc + int'($urandom_range(ctl_dmax, ctl_dmin));
            pend.push_back(p);
        end
        mc_rsp_push = 1'b0;
        if (spur_req) begin
            mc_rsp_push  = 1'b1;
            mc_rsp_rdctl = 32'hDEAD_0001;
            mc_rsp_data  = 64'h1234_5678_9ABC_DEF0;
            spur_req     = 0;
        end else if (pend.size() > 0 && pend[0].due <= cyc && !mc_rsp_stall) begin
            p = pend.pop_front();
            mc_rsp_push  = 1'b1;
            mc_rsp_rdctl = p.rdctl;
            mc_rsp_data  = p.data;
        end
    end

    int n_ld = 0, n_st = 0, n_rsp = 0;
    always @(negedge clk) begin
        if (mc_req_ld === 1'b1) n_ld++;
        if (mc_req_st === 1'b1) n_st++;
        if (up_rsp_push === 1'b1) n_rsp++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input bit ld, input bit st, input logic [47:0] a, input logic [63:0] w);
        @(negedge clk);
        up_req_ld = ld; up_req_st = st; up_req_vadr = a; up_req_wrd_rdctl = w;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_req(0, 0, '0, '0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; up_req_ld = 0; up_req_st = 0; mc_req_stall = 0; up_rsp_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ld0, st0, rsp0;
        bit ld;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        after_edge();
        chk("reset_outputs", {mc_req_ld, mc_req_st, up_rsp_push, up_req_stall, mc_rsp_stall, err}, 6'd0);

        // Single load: mc_req_ld at N+1, response back at N+4 with rdctl 5
        ctl_dmin = 2; ctl_dmax = 2;
        drive_req(1, 0, 48'h40, 64'h5);
        after_edge();
        chk("single_mc_req_ld", mc_req_ld, 1'b1);
        chk("single_vadr", mc_req_vadr, 48'h40);
        idle(1); after_edge();
        chk("single_rsp_n2", up_rsp_push, 1'b0);
        idle(1); after_edge();
        chk("single_rsp_n3", up_rsp_push, 1'b0);
        idle(1); after_edge();
        chk("single_rsp_n4", up_rsp_push, 1'b1);
        chk("single_rdctl", up_rsp_rdctl, 32'h5);
        idle(4);

        // Credit cap: 12 loads with response path stalled
        ctl_dmin = 1; ctl_dmax = 1;
        ld0 = n_ld; rsp0 = n_rsp;
        @(negedge clk);
        up_rsp_stall = 1'b1;
        for (int i = 0; i < 12; i++) drive_req(1, 0, 48'h1000 + 48'(i * 8), 64'(32'h100 + i));
        idle(30);
        chk("credit_ld_count", n_ld - ld0, 8);
        chk("credit_rsp_stall", mc_rsp_stall, 1'b1);
        chk("credit_no_rsp", n_rsp - rsp0, 0);
        up_rsp_stall = 1'b0;
        idle(40);
        chk("credit_ld_total", n_ld - ld0, 12);
        chk("credit_rsp_total", n_rsp - rsp0, 12);
        chk("credit_err", err, 1'b0);

        // Controller stall during 8 stores
        st0 = n_st;
        mc_req_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_req(0, 1, 48'h2000 + 48'(i), 64'hA000 + 64'(i));
            after_edge();
            if (i == 4) chk("stall_req_stall_lo", up_req_stall, 1'b0);
            if (i == 5) chk("stall_req_stall_hi", up_req_stall, 1'b1);
        end
        chk("stall_no_issue", n_st - st0, 0);
        idle(2);
        mc_req_stall = 1'b0;
        idle(20);
        chk("stall_st_count", n_st - st0, 8);
        chk("stall_err", err, 1'b0);

        // Overflow: 9 pushes into a stalled 8-deep FIFO
        mc_req_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_req(0, 1, 48'h3000 + 48'(i), 64'(i));
            after_edge();
            if (i == 7) chk("ovf_err_before", err, 1'b0);
            if (i == 8) chk("ovf_err_after", err, 1'b1);
        end
        idle(5);
        chk("ovf_err_sticky", err, 1'b1);
        reset_dut();
        after_edge();
        chk("ovf_err_cleared", err, 1'b0);

        // Spurious response with nothing outstanding
        rsp0 = n_rsp;
        @(negedge clk);
        spur_req = 1;
        idle(4);
        chk("spur_err", err, 1'b1);
        chk("spur_no_rsp", n_rsp - rsp0, 0);
        reset_dut();

        // Illegal simultaneous ld & st
        ld0 = n_ld; st0 = n_st;
        drive_req(1, 1, 48'h44, 64'h44);
        after_edge();
        chk("illegal_err", err, 1'b1);
        idle(3);
        chk("illegal_dropped", (n_ld - ld0) + (n_st - st0), 0);
        reset_dut();

        // Reset with 3 loads in flight
        ctl_dmin = 6; ctl_dmax = 6;
        for (int i = 0; i < 3; i++) drive_req(1, 0, 48'h5000 + 48'(i), 64'(32'h50 + i));
        @(negedge clk);
        rst = 1'b1; up_req_ld = 0;
        after_edge();
        chk("rst_mid_outputs", {mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, up_rsp_push,
                                up_rsp_rdctl, up_rsp_data, up_req_stall, mc_rsp_stall, err}, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        chk("rst_mid_late_rsp_err", err, 1'b1);
        reset_dut();
        after_edge();
        chk("rst_second_clear", err, 1'b0);

        // Randomized traffic
        ctl_dmin = 0; ctl_dmax = 4;
        ld0 = n_ld; rsp0 = n_rsp;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            mc_req_stall = ($urandom_range(0, 4) == 0);
            up_rsp_stall = ($urandom_range(0, 3) == 0);
            if (!up_req_stall && $urandom_range(0, 2) != 0) begin
                ld = 1'($urandom_range(0, 1));
                up_req_ld        = ld;
                up_req_st        = !ld;
                up_req_vadr      = 48'({$urandom(), $urandom()});
                up_req_wrd_rdctl = {$urandom(), $urandom()};
            end else begin
                up_req_ld = 0; up_req_st = 0;
            end
        end
        @(negedge clk);
        up_req_ld = 0; up_req_st = 0; mc_req_stall = 0; up_rsp_stall = 0;
        idle(100);
        chk("rand_err", err, 1'b0);
        chk("rand_all_answered", n_rsp - rsp0, n_ld - ld0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
